// File: rtl/log_dump_master_pkg.sv
// Shared definitions for the file_register GPIO command protocol and the
// log_dump_master state machines.
package log_dump_master_pkg;

  localparam int unsigned NB_C0M     = 8;
  localparam int unsigned NB_DATA    = 24;
  localparam int unsigned NB_INST    = NB_C0M + NB_DATA;
  localparam int unsigned EN_BIT     = NB_DATA - 1;
  localparam int unsigned NB_PAYLOAD = NB_DATA - 1;

  localparam logic [NB_C0M-1:0] OP_RESET   = 8'h01;
  localparam logic [NB_C0M-1:0] OP_RUN_MEM = 8'h05;
  localparam logic [NB_C0M-1:0] OP_RD_MEM  = 8'h06;
  localparam logic [NB_C0M-1:0] OP_IS_FULL = 8'h07;

  typedef enum logic [1:0] {
    ISS_IDLE,
    ISS_SETUP,
    ISS_STROBE,
    ISS_RELEASE
  } iss_state_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYS_RST_HI,
    ST_SYS_RST_LO,
    ST_ARM,
    ST_POLL,
    ST_RUN_OFF,
    ST_READ,
    ST_PUSH,
    ST_DONE
  } main_state_e;

  function automatic logic [NB_INST-1:0] make_inst(
    input logic [NB_C0M-1:0]     cmd,
    input logic                  en,
    input logic [NB_PAYLOAD-1:0] payload
  );
    return {cmd, en, payload};
  endfunction

endpackage

// File: rtl/log_dump_master_if.sv
// Bus between log_dump_master and its environment: the file_register
// instruction/response words and the logged-sample valid/ready stream.
interface log_dump_master_if;
  import log_dump_master_pkg::*;

  logic [NB_INST-1:0] o_cmd_to_fr;
  logic [NB_INST-1:0] i_data_from_fr;
  logic [NB_INST-1:0] o_sample;
  logic               o_sample_valid;
  logic               i_sample_ready;

  modport master (
    output o_cmd_to_fr,
    input  i_data_from_fr,
    output o_sample,
    output o_sample_valid,
    input  i_sample_ready
  );

  modport slave (
    input  o_cmd_to_fr,
    output i_data_from_fr,
    input  o_sample,
    input  o_sample_valid,
    output i_sample_ready
  );
endinterface

// File: rtl/log_dump_master_cmd_issuer.sv
// One file_register command transaction: SETUP (en=0, 1 cycle), STROBE
// (en=1, RESP_WAIT cycles, response captured on the last one), RELEASE
// (en=0, ack pulse). Total RESP_WAIT+2 cycles per request.
module log_dump_master_cmd_issuer
  import log_dump_master_pkg::*;
#(
  parameter int unsigned RESP_WAIT = 4
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  req_i,
  input  logic [NB_C0M-1:0]     opcode_i,
  input  logic [NB_PAYLOAD-1:0] payload_i,
  input  logic [NB_INST-1:0]    data_from_fr_i,
  output logic [NB_INST-1:0]    cmd_o,
  output logic [NB_INST-1:0]    resp_o,
  output logic                  ack_o
);

  localparam int unsigned NB_WAIT = (RESP_WAIT > 1) ? $clog2(RESP_WAIT) : 1;

  iss_state_e         state_q;
  logic [NB_WAIT-1:0] wait_q;
  logic [NB_INST-1:0] cmd_q;
  logic [NB_INST-1:0] resp_q;
  logic               ack_q;

  assign cmd_o  = cmd_q;
  assign resp_o = resp_q;
  assign ack_o  = ack_q;

  // Transaction sequencer; async reset drops en at once so the responder sees no edge
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ISS_IDLE;
      wait_q  <= '0;
      cmd_q   <= '0;
      resp_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        ISS_IDLE: begin
          if (req_i) begin
            cmd_q   <= make_inst(opcode_i, 1'b0, payload_i);
            state_q <= ISS_SETUP;
          end
        end
        ISS_SETUP: begin
          cmd_q[EN_BIT] <= 1'b1;
          wait_q        <= '0;
          state_q       <= ISS_STROBE;
        end
        ISS_STROBE: begin
          if (wait_q == NB_WAIT'(RESP_WAIT - 1)) begin
            resp_q        <= data_from_fr_i;
            cmd_q[EN_BIT] <= 1'b0;
            ack_q         <= 1'b1;
            state_q       <= ISS_RELEASE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ISS_RELEASE: state_q <= ISS_IDLE;
        default:     state_q <= ISS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/log_dump_master.sv
// Hardware initiator for file_register capture sessions: RESET pulse,
// RUN_MEM on, poll IS_FULL, RUN_MEM off, then RD_MEM of every BRAM address
// with each word streamed out on a valid/ready port.
// Optional macro LOG_DUMP_TIMEOUT_EN: abort polling after POLL_MAX IS_FULL
// transactions and raise the sticky o_error flag.
module log_dump_master
  import log_dump_master_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned NB_ADDR   = 10,
  parameter int unsigned RESP_WAIT = 4,
  parameter int unsigned POLL_MAX  = 1000000
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_start,
  log_dump_master_if.master bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  if (RESP_WAIT < 2 || NB_ADDR > NB_PAYLOAD || (2 ** NB_ADDR) < RAM_DEPTH || POLL_MAX < 1)
  begin : g_cfg_check
    $error("log_dump_master: unsupported parameter combination");
  end

  main_state_e           state_q;
  logic                  wait_q;
  logic                  req_q;
  logic [NB_C0M-1:0]     op_q;
  logic [NB_PAYLOAD-1:0] payload_q;
  logic [NB_ADDR-1:0]    addr_q;
  logic [NB_INST-1:0]    sample_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  iss_ack;
  logic [NB_INST-1:0]    iss_resp;
  logic                  txn_done;
  logic                  last_addr;

  logic                  cmd_state;
  logic [NB_C0M-1:0]     cur_op;
  logic [NB_PAYLOAD-1:0] cur_payload;

`ifdef LOG_DUMP_TIMEOUT_EN
  localparam int unsigned NB_POLL = $clog2(POLL_MAX + 1);
  logic [NB_POLL-1:0] poll_cnt_q;
  logic               error_q;
  logic               abort_q;
  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

  assign txn_done           = wait_q & iss_ack;
  assign last_addr          = (addr_q == NB_ADDR'(RAM_DEPTH - 1));
  assign bus.o_sample       = sample_q;
  assign bus.o_sample_valid = valid_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;

  log_dump_master_cmd_issuer #(
    .RESP_WAIT(RESP_WAIT)
  ) u_cmd_issuer (
    .clock          (clock),
    .i_reset        (i_reset),
    .req_i          (req_q),
    .opcode_i       (op_q),
    .payload_i      (payload_q),
    .data_from_fr_i (bus.i_data_from_fr),
    .cmd_o          (bus.o_cmd_to_fr),
    .resp_o         (iss_resp),
    .ack_o          (iss_ack)
  );

  // Command each transaction-issuing state sends to file_register
  always_comb begin
    cmd_state   = 1'b1;
    cur_op      = OP_RESET;
    cur_payload = '0;
    unique case (state_q)
      ST_SYS_RST_HI: cur_payload = NB_PAYLOAD'(1);
      ST_SYS_RST_LO: cur_payload = '0;
      ST_ARM: begin
        cur_op      = OP_RUN_MEM;
        cur_payload = NB_PAYLOAD'(1);
      end
      ST_POLL:       cur_op = OP_IS_FULL;
      ST_RUN_OFF:    cur_op = OP_RUN_MEM;
      ST_READ: begin
        cur_op      = OP_RD_MEM;
        cur_payload = NB_PAYLOAD'(addr_q);
      end
      default:       cmd_state = 1'b0;
    endcase
  end

  // Session FSM: one request per command state, advance on that request's ack
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      wait_q     <= 1'b0;
      req_q      <= 1'b0;
      op_q       <= '0;
      payload_q  <= '0;
      addr_q     <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef LOG_DUMP_TIMEOUT_EN
      poll_cnt_q <= '0;
      error_q    <= 1'b0;
      abort_q    <= 1'b0;
`endif
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      if (cmd_state && !wait_q) begin
        req_q     <= 1'b1;
        op_q      <= cur_op;
        payload_q <= cur_payload;
        wait_q    <= 1'b1;
      end
      if (txn_done) begin
        wait_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            busy_q  <= 1'b1;
            state_q <= ST_SYS_RST_HI;
`ifdef LOG_DUMP_TIMEOUT_EN
            poll_cnt_q <= '0;
            error_q    <= 1'b0;
            abort_q    <= 1'b0;
`endif
          end
        end
        ST_SYS_RST_HI: if (txn_done) state_q <= ST_SYS_RST_LO;
        ST_SYS_RST_LO: if (txn_done) state_q <= ST_ARM;
        ST_ARM:        if (txn_done) state_q <= ST_POLL;
        ST_POLL: begin
          if (txn_done) begin
            if (iss_resp[0]) begin
              state_q <= ST_RUN_OFF;
            end
`ifdef LOG_DUMP_TIMEOUT_EN
            else if (poll_cnt_q == NB_POLL'(POLL_MAX - 1)) begin
              abort_q <= 1'b1;
              error_q <= 1'b1;
              state_q <= ST_RUN_OFF;
            end else begin
              poll_cnt_q <= poll_cnt_q + 1'b1;
            end
`endif
          end
        end
        ST_RUN_OFF: begin
          if (txn_done) begin
            addr_q <= '0;
`ifdef LOG_DUMP_TIMEOUT_EN
            if (abort_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_READ;
            end
`else
            state_q <= ST_READ;
`endif
          end
        end
        ST_READ: begin
          if (txn_done) begin
            sample_q <= iss_resp;
            valid_q  <= 1'b1;
            state_q  <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (bus.i_sample_ready) begin
            valid_q <= 1'b0;
            if (last_addr) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_READ;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_dump_master.sv
// Scoreboard bench for log_dump_master with a behavioural file_register +
// BRAM responder (memory word = 0x100 + addr, full after 20 run cycles).
// With LOG_DUMP_TIMEOUT_EN defined only the timeout scenario runs.
module tb_log_dump_master;
  import log_dump_master_pkg::*;

  localparam int unsigned RAM_DEPTH = 8;
  localparam int unsigned NB_ADDR   = 3;
  localparam int unsigned RESP_WAIT = 4;
  localparam int unsigned POLL_MAX  = 3;
  localparam logic [31:0] EN_MASK   = 32'h0080_0000;

  logic clock   = 1'b0;
  logic i_reset = 1'b0;
  logic i_start = 1'b0;
  logic ready   = 1'b1;
  logic o_busy, o_done, o_error;

  logic [31:0] fr_data    = '0;
  logic        en_prev    = 1'b0;
  logic        run        = 1'b0;
  int          run_cnt    = 0;
  logic        full_never = 1'b0;

  log_dump_master_if bus ();
  assign bus.i_sample_ready = ready;
  assign bus.i_data_from_fr = fr_data;

  log_dump_master #(
    .RAM_DEPTH (RAM_DEPTH),
    .NB_ADDR   (NB_ADDR),
    .RESP_WAIT (RESP_WAIT),
    .POLL_MAX  (POLL_MAX)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_start (i_start),
    .bus     (bus),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_error (o_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int poll_seen = 0;
  int acc_cnt   = 0;
  int done_cnt  = 0;
  logic [31:0] exp_cmd[$];
  logic [31:0] exp_smp[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Responder: acts on each 0->1 edge of the enable bit
  always @(posedge clock) begin
    en_prev <= bus.o_cmd_to_fr[23];
    if (run) run_cnt <= run_cnt + 1;
    if (bus.o_cmd_to_fr[23] && !en_prev) begin
      case (bus.o_cmd_to_fr[31:24])
        8'h01: begin
          fr_data <= '0;
          if (bus.o_cmd_to_fr[0]) begin
            run     <= 1'b0;
            run_cnt <= 0;
          end
        end
        8'h05: run <= bus.o_cmd_to_fr[0];
        8'h07: fr_data <= {31'b0, (!full_never && run_cnt >= 20)};
        8'h06: fr_data <= 32'h100 + {9'b0, bus.o_cmd_to_fr[22:0]};
        default: ;
      endcase
    end
  end

  // Command monitor: transaction shape and command order
  initial begin
    logic [31:0] prev_cmd, strobe_word, cur;
    int strobe_len;
    prev_cmd = '0; strobe_word = '0; strobe_len = 0;
    forever begin
      @(negedge clock);
      if (!i_reset) begin
        prev_cmd   = '0;
        strobe_len = 0;
      end else begin
        cur = bus.o_cmd_to_fr;
        if (cur[23] && !prev_cmd[23]) begin
          check("setup_word", prev_cmd, cur & ~EN_MASK);
          strobe_len  = 1;
          strobe_word = cur;
          if (cur[31:24] == 8'h07) poll_seen++;
          else if (exp_cmd.size() == 0) check("cmd_extra", cur, 32'h0);
          else check("cmd", cur, exp_cmd.pop_front());
          if (cur[31:24] == 8'h06) check("rd_while_valid", {31'b0, bus.o_sample_valid}, 32'h0);
        end else if (cur[23]) begin
          strobe_len++;
          check("strobe_word", cur, strobe_word);
        end else if (prev_cmd[23]) begin
          check("strobe_len", strobe_len, RESP_WAIT);
          check("release_word", cur, strobe_word & ~EN_MASK);
        end
        prev_cmd = cur;
      end
    end
  end

  // Sample monitor: accepted words, hold under backpressure, valid drop
  initial begin
    logic pv, pr, pb;
    logic [31:0] ps;
    pv = 1'b0; pr = 1'b0; pb = 1'b0; ps = '0;
    forever begin
      @(negedge clock);
      if (!i_reset) begin
        pv = 1'b0; pr = 1'b0; pb = 1'b0;
      end else begin
        if (pv && pr) check("valid_drop", {31'b0, bus.o_sample_valid}, 32'h0);
        else if (pv && !pr) begin
          check("hold_valid", {31'b0, bus.o_sample_valid}, 32'h1);
          check("hold_word", bus.o_sample, ps);
        end
        if (bus.o_sample_valid && ready) begin
          if (exp_smp.size() == 0) check("sample_extra", exp_smp.size(), 32'h1);
          else check("sample", bus.o_sample, exp_smp.pop_front());
          acc_cnt++;
        end
        if (o_done) begin
          check("done_busy", {31'b0, o_busy}, 32'h0);
          check("busy_before_done", {31'b0, pb}, 32'h1);
          done_cnt++;
        end
        pv = bus.o_sample_valid; pr = ready; ps = bus.o_sample; pb = o_busy;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    check("done_seen", done_cnt, d0 + 1);
    repeat (3) step();
  endtask

  task automatic push_session();
    exp_cmd.push_back(32'h0180_0001);
    exp_cmd.push_back(32'h0180_0000);
    exp_cmd.push_back(32'h0580_0001);
    exp_cmd.push_back(32'h0580_0000);
    for (int a = 0; a < int'(RAM_DEPTH); a++) begin
      exp_cmd.push_back(32'h0680_0000 | 32'(a));
      exp_smp.push_back(32'h100 + 32'(a));
    end
  endtask

  task automatic check_drained(input int acc0, input int n_exp);
    check("cmds_left", exp_cmd.size(), 0);
    check("smps_left", exp_smp.size(), 0);
    check("accepted", acc_cnt - acc0, n_exp);
  endtask

  initial begin
    int acc0, k, p0;
    repeat (3) step();
    i_reset = 1'b1;
    repeat (10) step();
    check("rst_cmd", bus.o_cmd_to_fr, 32'h0);
    check("rst_sample", bus.o_sample, 32'h0);
    check("rst_valid", {31'b0, bus.o_sample_valid}, 32'h0);
    check("rst_busy", {31'b0, o_busy}, 32'h0);
    check("rst_done", {31'b0, o_done}, 32'h0);
    check("rst_error", {31'b0, o_error}, 32'h0);

`ifdef LOG_DUMP_TIMEOUT_EN
    full_never = 1'b1;
    for (int s = 0; s < 2; s++) begin
      exp_cmd.push_back(32'h0180_0001);
      exp_cmd.push_back(32'h0180_0000);
      exp_cmd.push_back(32'h0580_0001);
      exp_cmd.push_back(32'h0580_0000);
      acc0 = acc_cnt; p0 = poll_seen;
      pulse_start();
      step();
      check("to_busy", {31'b0, o_busy}, 32'h1);
      check("to_error_clr", {31'b0, o_error}, 32'h0);
      wait_done(2000);
      check("to_polls", poll_seen - p0, POLL_MAX);
      check("to_error", {31'b0, o_error}, 32'h1);
      check_drained(acc0, 0);
    end
`else
    // Session 1: free-flowing consumer, stray start mid-session
    push_session();
    acc0 = acc_cnt;
    pulse_start();
    step();
    check("s1_busy", {31'b0, o_busy}, 32'h1);
    repeat (30) step();
    pulse_start();
    wait_done(3000);
    check_drained(acc0, RAM_DEPTH);
    check("s1_polls", {31'b0, (poll_seen > 0)}, 32'h1);

    // Session 2: consumer stalls 5 cycles on sample 3
    push_session();
    acc0 = acc_cnt;
    pulse_start();
    k = 0;
    while (acc_cnt - acc0 < 3 && k < 3000) begin step(); k++; end
    check("s2_reach3", acc_cnt - acc0, 3);
    ready = 1'b0;
    k = 0;
    while (!bus.o_sample_valid && k < 200) begin step(); k++; end
    check("bp_valid", {31'b0, bus.o_sample_valid}, 32'h1);
    check("bp_sample", bus.o_sample, 32'h103);
    repeat (5) step();
    check("bp_sample_end", bus.o_sample, 32'h103);
    ready = 1'b1;
    wait_done(3000);
    check_drained(acc0, RAM_DEPTH);

    // Session 3: async reset during the RD_MEM strobe of address 4
    push_session();
    pulse_start();
    k = 0;
    while (bus.o_cmd_to_fr != 32'h0680_0004 && k < 3000) begin step(); k++; end
    check("reach_rd4", bus.o_cmd_to_fr, 32'h0680_0004);
    step();
    #2 i_reset = 1'b0;
    #1;
    check("arst_cmd", bus.o_cmd_to_fr, 32'h0);
    check("arst_busy", {31'b0, o_busy}, 32'h0);
    check("arst_valid", {31'b0, bus.o_sample_valid}, 32'h0);
    exp_cmd.delete();
    exp_smp.delete();
    repeat (3) step();
    i_reset = 1'b1;
    repeat (3) step();

    // Session 4: restart from SYS_RST and address 0
    push_session();
    acc0 = acc_cnt;
    pulse_start();
    wait_done(3000);
    check_drained(acc0, RAM_DEPTH);
    check("err_tied", {31'b0, o_error}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/log_dump_master.md
Name: log_dump_master

Overview:
- Hardware initiator for the 32-bit GPIO command interface served by file_register. It drives the instruction word and reads the response word, taking the place of the soft micro for capture sessions.
- On start it issues RESET, then RUN_MEM, then polls IS_FULL, then issues RD_MEM for every BRAM address.
- Each logged word is streamed out on a valid/ready port, for a UART packer or a checker.

Parameters:
- NB_C0M, 8, command field width.
- NB_DATA, 24, data field width.
- NB_INST, 32, instruction/response word width (= NB_C0M+NB_DATA).
- RAM_DEPTH, 1024, number of log words to read back.
- NB_ADDR, 10, address width (clogb2(RAM_DEPTH-1)); must fit in data[22:0].
- RESP_WAIT, 4, cycles the enable bit is held high before the response is sampled (≥2).
- POLL_MAX, 1000000, IS_FULL polls before timeout (used only with the optional feature).

Ports:
- clock  in  1  system clock
- i_reset  in  1  asynchronous active-low reset
- i_start  in  1  1-cycle pulse: begin session
- i_data_from_fr  in  NB_INST  response word from file_register
- o_cmd_to_fr  out  NB_INST  instruction word {cmd[NB_C0M-1:0], en, payload[NB_DATA-2:0]}
- o_sample  out  NB_INST  logged word read back
- o_sample_valid  out  1  o_sample valid
- i_sample_ready  in  1  consumer accepts o_sample
- o_busy  out  1  session in progress
- o_done  out  1  1-cycle pulse, session finished
- o_error  out  1  sticky timeout flag (optional feature; tied 0 otherwise)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: o_cmd_to_fr=0, o_sample=0, o_sample_valid=0, o_busy=0, o_done=0, o_error=0, address counter=0, FSM=IDLE.
- Command transaction (cmd_issuer):
  - SETUP: 1 cycle; cmd and payload driven, en=0.
  - STROBE: RESP_WAIT cycles; same word with en=1.
  - At the last STROBE cycle, i_data_from_fr is registered into the response register.
  - RELEASE: 1 cycle; en=0, ack pulse to the main FSM.
  - Transaction length is RESP_WAIT+2 cycles. The responder acts on the 0→1 edge of en.
- Opcodes: RESET=0x01, RUN_MEM=0x05, RD_MEM=0x06, IS_FULL=0x07.
- Main FSM:
  - IDLE: o_busy=0. i_start → SYS_RST, o_busy=1.
  - SYS_RST: issue RESET with payload 1, then RESET with payload 0 (pulses reset_from_micro) → ARM.
  - ARM: issue RUN_MEM with payload 1 → POLL.
  - POLL: issue IS_FULL. If response bit0=1 → RUN_OFF; else reissue.
  - RUN_OFF: issue RUN_MEM with payload 0; clear the address counter → READ.
  - READ: issue RD_MEM with payload=address (zero-extended) → PUSH.
  - PUSH: o_sample=response, o_sample_valid=1. Hold both until i_sample_ready; the word stays stable while valid=1 and ready=0.
    - On acceptance with address=RAM_DEPTH-1 → DONE.
    - Otherwise increment the address → READ.
  - DONE: o_done=1 for 1 cycle, o_busy=0 → IDLE.
- Boundaries:
  - i_start while busy is ignored.
  - valid and ready high in the same cycle count as an accept; valid drops the next cycle.
  - The address counter never wraps mid-session; it resets to 0 only in RUN_OFF.
  - An async reset mid-transaction forces en=0 immediately. The responder sees no new edge, and the half-read session is abandoned.
  - The response register is only updated inside STROBE.

Optional Feature:
- Macro: LOG_DUMP_TIMEOUT_EN.
- Defined:
  - A poll counter counts IS_FULL transactions in POLL.
  - On reaching POLL_MAX, the block issues RUN_MEM with payload 0, sets o_error=1 (sticky until the next i_start or reset), pulses o_done, and returns to IDLE with no samples pushed.
- Undefined: POLL loops indefinitely; o_error is tied to 0 and the counter is not synthesised.

Decomposition:
- Shared package/header (with file_register):
  - opcode localparams RESET…BER_HIGH;
  - field widths NB_C0M, NB_DATA, NB_INST;
  - enable-bit index NB_DATA-1.
- Sub-module cmd_issuer: SETUP/STROBE/RELEASE sequencer with req/ack, opcode/payload in, response out.
- Main FSM and address counter stay in log_dump_master.

Test Plan (RAM_DEPTH=8, RESP_WAIT=4, behavioural file_register+bram model, full asserted after 20 run cycles):
- Reset, then idle for 10 cycles → all outputs 0, o_cmd_to_fr=0x00000000.
- i_start → o_cmd_to_fr shows 0x01000001 with en low then high for 4 cycles; then 0x01000000; then 0x05800001 (en high). Each strobe lasts exactly 4 cycles.
- Full model: memory preloaded with 0x100+addr, ready always 1 → 8 samples 0x100..0x107 in order, RD_MEM payloads 0..7. o_done pulses once, o_busy falls the same cycle.
- Backpressure: ready low for 5 cycles at sample 3 → o_sample=0x103 held stable with valid=1; no RD_MEM issued until accept.
- i_reset asserted mid-STROBE of RD_MEM addr 4 → o_cmd_to_fr=0 asynchronously; a later i_start restarts from SYS_RST and addr 0.
- LOG_DUMP_TIMEOUT_EN, POLL_MAX=3, full never set → 3 IS_FULL transactions, then RUN_MEM payload 0, o_error=1, o_done pulse, zero samples.
